// File: rtl/memory_bus_responder.sv
// Single-outstanding memory-bus responder backed by a word-addressed store.
// Reads return one tagged response after READ_LATENCY cycles; writes are silent.
module memory_bus_responder #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned SOURCE_WIDTH = 8,
  parameter int unsigned MEM_WORDS    = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [ADDR_WIDTH-1:0]   req_address,
  input  logic [SOURCE_WIDTH-1:0] req_source,
  input  logic [DATA_WIDTH-1:0]   req_payload,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [SOURCE_WIDTH-1:0] rsp_source,
  output logic [DATA_WIDTH-1:0]   rsp_payload,
  output logic                    err_addr
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned TOP   = 3 + IDX_W;
  localparam logic [63:0]           POISON64 = 64'hDEADBEEF_DEADBEEF;
  localparam logic [DATA_WIDTH-1:0] POISON   = DATA_WIDTH'(POISON64);
  localparam logic [3:0]            LAT_M1   = 4'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ_WAIT,
    S_RESPOND
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic [DATA_WIDTH-1:0]   r_mem [MEM_WORDS];
  logic [IDX_W-1:0]        r_index;
  logic                    r_illegal;
  logic [SOURCE_WIDTH-1:0] r_req_source;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_count;
  logic [SOURCE_WIDTH-1:0] r_rsp_source;
  logic [DATA_WIDTH-1:0]   r_rsp_payload;
  logic                    r_err;

  logic             w_req_ready;
  logic             w_rsp_valid;
  logic             w_accept;
  logic             w_mem_we;
  logic             w_capture;
  logic             w_err_nx;
  logic             w_misaligned;
  logic             w_out_of_range;
  logic             w_illegal;
  logic [IDX_W-1:0] w_index;

  assign w_index      = req_address[3 +: IDX_W];
  assign w_misaligned = |req_address[2:0];

  // Any set bit above the word-index field addresses beyond the store.
  generate
    if (ADDR_WIDTH > TOP) begin : g_range
      assign w_out_of_range = |req_address[ADDR_WIDTH-1:TOP];
    end else begin : g_no_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_illegal = w_misaligned | w_out_of_range;
  assign w_accept  = w_req_ready & req_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_mem_we    = 1'b0;
    w_capture   = 1'b0;
    w_err_nx    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (req_valid) begin
          w_state_nx = req_write ? S_WRITE : S_READ_WAIT;
        end
      end
      S_WRITE: begin
        w_mem_we   = ~r_illegal;
        w_err_nx   = r_illegal;
        w_state_nx = S_IDLE;
      end
      S_READ_WAIT: begin
        if (r_count == '0) begin
          w_capture  = 1'b1;
          w_err_nx   = r_illegal;
          w_state_nx = S_RESPOND;
        end
      end
      S_RESPOND: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) begin
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_index       <= '0;
      r_illegal     <= 1'b0;
      r_req_source  <= '0;
      r_wdata       <= '0;
      r_count       <= '0;
      r_rsp_source  <= '0;
      r_rsp_payload <= '0;
      r_err         <= 1'b0;
    end else begin
      r_err <= w_err_nx;
      if (w_accept) begin
        r_index      <= w_index;
        r_illegal    <= w_illegal;
        r_req_source <= req_source;
        r_wdata      <= req_payload;
        r_count      <= req_write ? 4'd0 : LAT_M1;
      end else if ((r_state == S_READ_WAIT) && (r_count != '0)) begin
        r_count <= r_count - 4'd1;
      end
      if (w_capture) begin
        r_rsp_payload <= r_illegal ? POISON : r_mem[r_index];
        r_rsp_source  <= r_req_source;
      end
    end
  end

  // Backing store is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_index] <= r_wdata;
    end
  end

  assign req_ready   = w_req_ready;
  assign rsp_valid   = w_rsp_valid;
  assign rsp_source  = r_rsp_source;
  assign rsp_payload = r_rsp_payload;
  assign err_addr    = r_err;

endmodule
